// File: rtl/spi_shift_engine.sv
// SPI shift engine: one parallel word out, one parallel word in, a bit at a time.
// Latency: load->first serial bit 1 cycle; each accepted shift updates outputs 1 cycle later.
// Flow control: none; shift pulses are ignored while idle, and load always wins.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   parallel_in, load - word to transmit and its start strobe
//   shift, serial_in  - advance by one bit, with the received bit sampled on the same edge
//   serial_out        - current transmit bit (registered)
//   parallel_out      - live view of the shift register, holding the received word when done
//   busy, done        - transfer in progress; one-cycle completion pulse
//   bit_cnt           - shifts completed in the current transfer
module spi_shift_engine #(
   parameter int WIDTH     = 8,    // 2..32
   parameter bit MSB_FIRST = 1'b0,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load,
   input  logic             shift,
   input  logic             serial_in,
   output logic             serial_out,
   output logic [WIDTH-1:0] parallel_out,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    bit_cnt
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] data;

   // The register itself is the output; there is no path from any input to it.
   assign parallel_out = data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         data       <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bit_cnt    <= '0;
      end else begin
         done <= 1'b0;
         if (load) begin
            // Load wins over a simultaneous shift, and it also aborts a running transfer.
            state      <= XFER;
            data       <= parallel_in;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            serial_out <= MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
         end else if (shift && state == XFER) begin
            // serial_out takes the bit that becomes the new leading edge of the word.
            // It is read from the old data so that it stays registered.
            if (MSB_FIRST) begin
               data       <= {data[WIDTH-2:0], serial_in};
               serial_out <= data[WIDTH-2];
            end else begin
               data       <= {serial_in, data[WIDTH-1:1]};
               serial_out <= data[1];
            end
            if (bit_cnt == LAST_BIT) begin
               state   <= IDLE;
               busy    <= 1'b0;
               bit_cnt <= '0;
               done    <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine. It runs two instances:
//   A: WIDTH=8, LSB-first
//   B: WIDTH=16, MSB-first
// The reference treats a transfer as a bit stream: first the transmitted word in
// wire order, then the received bits in arrival order. After k shifts, the register
// is the WIDTH-bit window of that stream starting at bit k.
module tb_spi_shift_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A
   logic [7:0]  pin_a = '0;
   logic        ld_a = 1'b0, sh_a = 1'b0, si_a = 1'b0;
   logic        so_a, busy_a, done_a;
   logic [7:0]  po_a;
   logic [3:0]  cnt_a;
   // instance B
   logic [15:0] pin_b = '0;
   logic        ld_b = 1'b0, sh_b = 1'b0, si_b = 1'b0;
   logic        so_b, busy_b, done_b;
   logic [15:0] po_b;
   logic [4:0]  cnt_b;

   spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (
      .clk(clk), .rst(rst), .parallel_in(pin_a), .load(ld_a), .shift(sh_a),
      .serial_in(si_a), .serial_out(so_a), .parallel_out(po_a), .busy(busy_a),
      .done(done_a), .bit_cnt(cnt_a));

   spi_shift_engine #(.WIDTH(16), .MSB_FIRST(1'b1)) u_b (
      .clk(clk), .rst(rst), .parallel_in(pin_b), .load(ld_b), .shift(sh_b),
      .serial_in(si_b), .serial_out(so_b), .parallel_out(po_b), .busy(busy_b),
      .done(done_b), .bit_cnt(cnt_b));

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] s_m[2]   = '{64'd0, 64'd0};  // stream: tx bits in wire order, then rx bits
   int          k_m[2]   = '{0, 0};          // shifts taken since the last load
   bit          busy_m[2] = '{1'b0, 1'b0};
   bit          done_m[2] = '{1'b0, 1'b0};

   function automatic int wid(input int id);
      return (id == 0) ? 8 : 16;
   endfunction

   function automatic logic [31:0] exp_po(input int id);
      logic [31:0] r = '0;
      for (int i = 0; i < wid(id); i++) begin
         if (id == 0) r[i] = s_m[id][k_m[id] + i];
         else         r[wid(id) - 1 - i] = s_m[id][k_m[id] + i];
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int id = 0; id < 2; id++) begin
            s_m[id] = '0; k_m[id] = 0; busy_m[id] = 1'b0; done_m[id] = 1'b0;
         end
      end else begin
         for (int id = 0; id < 2; id++) begin
            logic        l, s, i;
            logic [31:0] p;
            int          w;
            w = wid(id);
            l = (id == 0) ? ld_a : ld_b;
            s = (id == 0) ? sh_a : sh_b;
            i = (id == 0) ? si_a : si_b;
            p = (id == 0) ? 32'(pin_a) : 32'(pin_b);
            if (l) begin
               s_m[id] = '0;
               for (int j = 0; j < w; j++)
                  s_m[id][j] = (id == 1) ? p[w - 1 - j] : p[j];
               k_m[id] = 0; busy_m[id] = 1'b1; done_m[id] = 1'b0;
            end else if (s && busy_m[id]) begin
               s_m[id][w + k_m[id]] = i;
               k_m[id]++;
               done_m[id] = (k_m[id] == w);
               if (k_m[id] == w) busy_m[id] = 1'b0;
            end else begin
               done_m[id] = 1'b0;
            end
         end
      end
   end

   task automatic check_all();
      chk("a_serial_out", 32'(so_a), 32'(s_m[0][k_m[0]]));
      chk("a_parallel_out", 32'(po_a), exp_po(0));
      chk("a_busy", 32'(busy_a), 32'(busy_m[0]));
      chk("a_done", 32'(done_a), 32'(done_m[0]));
      chk("a_bit_cnt", 32'(cnt_a), busy_m[0] ? 32'(k_m[0]) : 32'd0);
      chk("b_serial_out", 32'(so_b), 32'(s_m[1][k_m[1]]));
      chk("b_parallel_out", 32'(po_b), exp_po(1));
      chk("b_busy", 32'(busy_b), 32'(busy_m[1]));
      chk("b_done", 32'(done_b), 32'(done_m[1]));
      chk("b_bit_cnt", 32'(cnt_b), busy_m[1] ? 32'(k_m[1]) : 32'd0);
   endtask

   // Outputs are sampled on the falling edge, away from the active edge.
   always @(negedge clk) if (chk_en) check_all();

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc_a(input bit l, input bit s, input bit i, input logic [7:0] p);
      ld_a = l; sh_a = s; si_a = i; pin_a = p;
      step();
      ld_a = 1'b0; sh_a = 1'b0;
   endtask

   task automatic cyc_b(input bit l, input bit s, input bit i, input logic [15:0] p);
      ld_b = l; sh_b = s; si_b = i; pin_b = p;
      step();
      ld_b = 1'b0; sh_b = 1'b0;
   endtask

   initial begin
      logic [7:0] tx_a;
      logic [7:0] rx_a;
      int nd;

      #3 rst = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_a_so", 32'(so_a), 32'd0);
      chk("rst_a_po", 32'(po_a), 32'd0);
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);

      // Shifts while idle must be ignored.
      for (int j = 0; j < 5; j++) begin
         cyc_a(1'b0, 1'b1, 1'b1, 8'h00);
         chk("idle_so", 32'(so_a), 32'd0);
         chk("idle_done", 32'(done_a), 32'd0);
      end
      chk("idle_cnt", 32'(cnt_a), 32'd0);
      chk("idle_busy", 32'(busy_a), 32'd0);

      // LSB-first: transmit 0xA5, receive 0,0,1,1,1,1,0,0.
      tx_a = 8'hA5;
      rx_a = 8'h3C;
      cyc_a(1'b1, 1'b0, 1'b0, tx_a);
      chk("lsb_first_bit", 32'(so_a), 32'(tx_a[0]));
      for (int j = 0; j < 8; j++) begin
         cyc_a(1'b0, 1'b1, rx_a[j], 8'h00);
         if (j < 7) chk("lsb_so_seq", 32'(so_a), 32'(tx_a[j + 1]));
      end
      chk("lsb_po", 32'(po_a), 32'h3C);
      chk("lsb_done", 32'(done_a), 32'd1);
      chk("lsb_busy", 32'(busy_a), 32'd0);
      chk("lsb_cnt", 32'(cnt_a), 32'd0);
      step();
      chk("lsb_done_drop", 32'(done_a), 32'd0);
      chk("lsb_po_hold", 32'(po_a), 32'h3C);

      // MSB-first, 16 bits: transmit 0x8001 while receiving all ones.
      nd = 0;
      cyc_b(1'b1, 1'b0, 1'b0, 16'h8001);
      chk("msb_first_bit", 32'(so_b), 32'd1);
      for (int j = 1; j <= 16; j++) begin
         cyc_b(1'b0, 1'b1, 1'b1, 16'h0000);
         if (done_b) nd++;
         if (j <= 15) chk("msb_so_seq", 32'(so_b), (j == 15) ? 32'd1 : 32'd0);
      end
      chk("msb_po", 32'(po_b), 32'hFFFF);
      step();
      if (done_b) nd++;
      chk("msb_done_count", 32'(nd), 32'd1);

      // A load during a transfer aborts it. A shift in the same cycle is discarded.
      cyc_a(1'b1, 1'b0, 1'b0, 8'hFF);
      for (int j = 0; j < 3; j++) cyc_a(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'h00);
      cyc_a(1'b1, 1'b1, 1'b1, 8'h00);
      chk("abort_cnt", 32'(cnt_a), 32'd0);
      chk("abort_so", 32'(so_a), 32'd0);
      chk("abort_done", 32'(done_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd1);
      nd = 0;
      for (int j = 0; j < 8; j++) begin
         cyc_a(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'h00);
         if (done_a) nd++;
      end
      step();
      if (done_a) nd++;
      chk("abort_done_count", 32'(nd), 32'd1);

      // Reset arriving between clock edges, in the middle of a transfer.
      cyc_a(1'b1, 1'b0, 1'b0, 8'h5A);
      for (int j = 0; j < 4; j++) cyc_a(1'b0, 1'b1, 1'b1, 8'h00);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_so", 32'(so_a), 32'd0);
      chk("mid_rst_po", 32'(po_a), 32'd0);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_done", 32'(done_a), 32'd0);
      chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      nd = 0;
      for (int j = 0; j < 6; j++) begin
         cyc_a(1'b0, 1'b1, 1'b1, 8'h00);
         if (done_a) nd++;
      end
      chk("mid_rst_no_done", 32'(nd), 32'd0);

      // Random traffic on both instances, including occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         ld_a = ($urandom_range(0, 11) == 0); sh_a = 1'($urandom_range(0, 1));
         si_a = 1'($urandom_range(0, 1));     pin_a = 8'($urandom);
         ld_b = ($urandom_range(0, 23) == 0); sh_b = ($urandom_range(0, 3) != 0);
         si_b = 1'($urandom_range(0, 1));     pin_b = 16'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
         end
         step();
      end
      ld_a = 1'b0; sh_a = 1'b0; ld_b = 1'b0; sh_b = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Parameters
REQ-001 The block SHALL provide parameter WIDTH, default 8, setting the shift word length; legal range is 2..32.
REQ-002 The block SHALL provide parameter MSB_FIRST, default 0; 0 selects LSB-first and 1 selects MSB-first transmit and receive order.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port parallel_in, input, WIDTH bits: word to transmit, captured on load.
REQ-006 The block SHALL have port load, input, 1 bit: start a transfer with parallel_in.
REQ-007 The block SHALL have port shift, input, 1 bit: advance the transfer by one bit.
REQ-008 The block SHALL have port serial_in, input, 1 bit: received serial bit, sampled on a shift.
REQ-009 The block SHALL have port serial_out, output, 1 bit: registered transmit bit.
REQ-010 The block SHALL have port parallel_out, output, WIDTH bits: direct view of the internal shift register.
REQ-011 The block SHALL have port busy, output, 1 bit: transfer in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-013 The block SHALL have port bit_cnt, output, $clog2(WIDTH+1) bits: number of shifts completed in the current transfer.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE (busy=0) and XFER (busy=1).
REQ-015 On load=1, from either state, the block SHALL update as follows:
- data <= parallel_in
- bit_cnt <= 0
- busy <= 1
- done <= 0
- serial_out <= parallel_in[0] if MSB_FIRST=0, else parallel_in[WIDTH-1]
REQ-016 When load and shift are both 1 in a cycle, load SHALL take priority and the shift SHALL be discarded.
REQ-017 In XFER with shift=1 and load=0, for MSB_FIRST=0 the block SHALL update data <= {serial_in, data[WIDTH-1:1]} and serial_out <= data[1].
REQ-018 In XFER with shift=1 and load=0, for MSB_FIRST=1 the block SHALL update data <= {data[WIDTH-2:0], serial_in} and serial_out <= data[WIDTH-2].
REQ-019 Each accepted shift SHALL increment bit_cnt by 1.
REQ-020 When the accepted shift occurs with bit_cnt == WIDTH-1, that shift SHALL end the transfer:
- next state IDLE, busy <= 0
- bit_cnt <= 0
- done <= 1 for exactly the following cycle
REQ-021 After completion, parallel_out SHALL hold the WIDTH received bits in arrival order per MSB_FIRST until the next load or reset.
REQ-022 shift=1 in IDLE SHALL be ignored; data, serial_out and bit_cnt remain unchanged.
REQ-023 In any cycle with neither load nor an accepted shift, all registers SHALL hold their values, except done, which returns to 0.
REQ-024 A load during XFER SHALL abort the current transfer without a done pulse and restart per REQ-015.
REQ-025 Every output SHALL be driven directly from a register, with no combinational path from any input to any output.

Reset
REQ-026 While rst=0, regardless of clk, the block SHALL force data=0, serial_out=0, busy=0, done=0, bit_cnt=0, and state IDLE.
REQ-027 The first rising edge of clk after rst deasserts SHALL be processed normally.
REQ-028 Reset asserted mid-transfer SHALL abort it, with no done pulse generated.

Verification
REQ-029 LSB-first default: load 0xA5, then 8 shifts with serial_in bits 0,0,1,1,1,1,0,0 -> serial_out 1,0,1,0,0,1,0,1 (first bit valid after load); parallel_out=0x3C; done high one cycle after the 8th shift; busy=0; bit_cnt=0.
REQ-030 MSB_FIRST=1, WIDTH=16: load 0x8001, 16 shifts with serial_in=1 -> serial_out 1, fourteen 0s, 1; parallel_out=0xFFFF; single done pulse.
REQ-031 Idle shift: after reset, 5 shifts with no load -> serial_out=0, bit_cnt=0, busy=0, done never asserted.
REQ-032 Abort by load: load 0xFF, 3 shifts, then load with shift=1 and parallel_in=0x00 -> bit_cnt=0, serial_out=0, no done; 8 further shifts complete normally with one done pulse.
REQ-033 Reset mid-transfer: load 0x5A, 4 shifts, assert rst between clock edges -> all outputs 0 immediately; no done after release.
